// File: rtl/or_nor_sweep_ctrl.sv
// Self-test sequencer for the OR/NOR unit (w = e ? NOR(x,y) : OR(x,y)).
// It drives all eight {x,y,e} vectors, samples w, and scores the captured vector against a golden one.
module or_nor_sweep_ctrl #(
   parameter int unsigned SETTLE_CYC = 1,
   parameter logic [7:0]  EXPECTED   = 8'h56
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       w,
   output logic       x,
   output logic       y,
   output logic       e,
   output logic       busy,
   output logic       done,
   output logic [7:0] result,
   output logic       pass,
   output logic [3:0] mismatch_cnt,
   output logic [2:0] first_mismatch
);

   typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

   localparam logic [3:0] CntInit = 4'(SETTLE_CYC - 1);

   state_e     state;
   logic [2:0] idx;
   logic [3:0] cnt;
   logic       miss;
   logic [7:0] result_upd;

   assign miss = (w != EXPECTED[idx]);

   // The vector as it will stand once this sample is written; pass is scored from it.
   always_comb begin
      result_upd      = result;
      result_upd[idx] = w;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= StIdle;
         idx            <= 3'd0;
         cnt            <= 4'd0;
         {x, y, e}      <= 3'b000;
         busy           <= 1'b0;
         done           <= 1'b0;
         result         <= 8'h00;
         pass           <= 1'b0;
         mismatch_cnt   <= 4'd0;
         first_mismatch <= 3'd0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start) begin
                  state          <= StSettle;
                  idx            <= 3'd0;
                  {x, y, e}      <= 3'b000;
                  cnt            <= CntInit;
                  busy           <= 1'b1;
                  result         <= 8'h00;
                  pass           <= 1'b0;
                  mismatch_cnt   <= 4'd0;
                  first_mismatch <= 3'd0;
               end
            end
            StSettle: begin
               if (cnt == 4'd0) state <= StSample;
               else             cnt   <= cnt - 4'd1;
            end
            StSample: begin
               result <= result_upd;
               if (miss) begin
                  mismatch_cnt <= mismatch_cnt + 4'd1;
                  if (mismatch_cnt == 4'd0) first_mismatch <= idx;
               end
               if (idx == 3'd7) begin
                  state <= StDone;
                  done  <= 1'b1;
                  pass  <= (result_upd == EXPECTED);
               end else begin
                  idx       <= idx + 3'd1;
                  {x, y, e} <= idx + 3'd1;
                  cnt       <= CntInit;
                  state     <= StSettle;
               end
            end
            StDone: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_or_nor_sweep_ctrl.sv
// Bench for or_nor_sweep_ctrl: a behavioural OR/NOR unit (correct, stuck-at-0 or inverted)
// drives w, and expected sweep outcomes are queued on start and popped when done pulses.
module tb_or_nor_sweep_ctrl;

   localparam logic [7:0] GOLD = 8'h56;

   typedef struct packed {
      logic [7:0] res;
      logic       pass;
      logic [3:0] cnt;
      logic [2:0] first;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       go;
   logic       sel;
   logic [1:0] mode;
   int         n_checks = 0;
   int         n_fail = 0;
   exp_t       sb[$];

   logic       start1, w1, x1, y1, e1, busy1, done1, pass1;
   logic [7:0] res1;
   logic [3:0] cnt1;
   logic [2:0] first1;
   logic       start3, w3, x3, y3, e3, busy3, done3, pass3;
   logic [7:0] res3;
   logic [3:0] cnt3;
   logic [2:0] first3;

   logic [2:0] bxye;
   logic       bbusy, bdone, bpass;
   logic [7:0] bres;
   logic [3:0] bcnt;
   logic [2:0] bfirst;

   always #5 clk = ~clk;

   function automatic logic unit_w(logic [1:0] m, logic xx, logic yy, logic ee);
      logic c;
      c = ee ? ~(xx | yy) : (xx | yy);
      case (m)
         2'd0:    return c;
         2'd1:    return 1'b0;
         default: return ~c;
      endcase
   endfunction

   function automatic exp_t model(logic [1:0] m);
      exp_t r;
      logic [2:0] v;
      logic b;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         b = unit_w(m, v[2], v[1], v[0]);
         r.res[i] = b;
         if (b != GOLD[i]) begin
            if (r.cnt == 4'd0) r.first = v;
            r.cnt = r.cnt + 4'd1;
         end
      end
      r.pass = (r.res == GOLD);
      return r;
   endfunction

   assign start1 = go & ~sel;
   assign start3 = go & sel;
   assign w1 = unit_w(mode, x1, y1, e1);
   assign w3 = unit_w(mode, x3, y3, e3);

   assign bxye   = sel ? {x3, y3, e3} : {x1, y1, e1};
   assign bbusy  = sel ? busy3 : busy1;
   assign bdone  = sel ? done3 : done1;
   assign bpass  = sel ? pass3 : pass1;
   assign bres   = sel ? res3 : res1;
   assign bcnt   = sel ? cnt3 : cnt1;
   assign bfirst = sel ? first3 : first1;

   or_nor_sweep_ctrl #(.SETTLE_CYC(1), .EXPECTED(8'h56)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .w(w1), .x(x1), .y(y1), .e(e1),
      .busy(busy1), .done(done1), .result(res1), .pass(pass1),
      .mismatch_cnt(cnt1), .first_mismatch(first1)
   );

   or_nor_sweep_ctrl #(.SETTLE_CYC(3), .EXPECTED(8'h56)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .w(w3), .x(x3), .y(y3), .e(e3),
      .busy(busy3), .done(done3), .result(res3), .pass(pass3),
      .mismatch_cnt(cnt3), .first_mismatch(first3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered at the negedge of cycle 1 after the accept edge; leaves at the done cycle.
   task automatic wait_done(input int per, input string tag, input int pulse_c,
                            input bit go_done, input bit keep_go);
      int c;
      bit seen;
      c = 1;
      seen = 0;
      while (c <= 200 && !seen) begin
         if (!keep_go) go = (c == pulse_c);
         if (c <= 8 * per) chk({tag, "_hold"}, 32'(bxye), 32'((c - 1) / per));
         if (bdone === 1'b1) begin
            seen = 1;
            if (go_done) go = 1'b1;
         end else begin
            @(negedge clk);
            c++;
         end
      end
      chk({tag, "_latency"}, seen ? c : 0, 8 * per + 1);
   endtask

   task automatic check_out(input string tag);
      exp_t ex;
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
         ex = sb.pop_front();
         chk({tag, "_result"}, 32'(bres), 32'(ex.res));
         chk({tag, "_pass"}, 32'(bpass), 32'(ex.pass));
         chk({tag, "_mismatch_cnt"}, 32'(bcnt), 32'(ex.cnt));
         chk({tag, "_first_mismatch"}, 32'(bfirst), 32'(ex.first));
      end
   endtask

   task automatic accept(input string tag);
      go = 1'b1;
      @(negedge clk);
      go = 1'b0;
      chk({tag, "_busy_after_accept"}, 32'(bbusy), 32'd1);
   endtask

   task automatic sweep(input logic [1:0] m, input int per, input string tag);
      mode = m;
      sb.push_back(model(m));
      accept(tag);
      wait_done(per, tag, 0, 0, 0);
      check_out(tag);
      @(negedge clk);
      chk({tag, "_idle_after"}, 32'({bbusy, bdone}), 32'd0);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      go = 1'b0;
      sel = 1'b0;
      mode = 2'd0;
      repeat (2) @(negedge clk);
      chk("reset_dut1", 32'({bxye, bbusy, bdone, bres, bpass, bcnt, bfirst}), 32'd0);
      sel = 1'b1;
      #1 chk("reset_dut3", 32'({bxye, bbusy, bdone, bres, bpass, bcnt, bfirst}), 32'd0);
      sel = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      sweep(2'd0, 2, "correct");
      sweep(2'd1, 2, "stuck0");
      sweep(2'd2, 2, "inverse");

      // Stray start pulses at idx 2 and during DONE must not disturb the sweep.
      mode = 2'd0;
      sb.push_back(model(2'd0));
      accept("stray");
      wait_done(2, "stray", 5, 1, 0);
      check_out("stray");
      @(negedge clk);
      go = 1'b0;
      chk("stray_idle1", 32'({bbusy, bdone}), 32'd0);
      @(negedge clk);
      chk("stray_idle2", 32'({bbusy, bdone}), 32'd0);

      // Start held high: the next sweep is accepted from the first IDLE cycle.
      sb.push_back(model(2'd0));
      sb.push_back(model(2'd0));
      go = 1'b1;
      @(negedge clk);
      chk("held_busy_after_accept", 32'(bbusy), 32'd1);
      wait_done(2, "held", 0, 0, 1);
      check_out("held");
      @(negedge clk);
      chk("held_idle_gap", 32'({bbusy, bdone}), 32'd0);
      @(negedge clk);
      go = 1'b0;
      chk("held_relaunch_busy", 32'(bbusy), 32'd1);
      wait_done(2, "held2", 0, 0, 0);
      check_out("held2");
      @(negedge clk);

      // Asynchronous reset while idx 3 is settling.
      sb.push_back(model(2'd0));
      accept("abort");
      k = 0;
      while (bxye !== 3'd3 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("abort_reached_idx3", 32'(bxye), 32'd3);
      #2 rst_n = 1'b0;
      #1 chk("abort_outputs_zero", 32'({bxye, bbusy, bdone, bres, bpass, bcnt, bfirst}), 32'd0);
      sb.delete(sb.size() - 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      sweep(2'd0, 2, "after_reset");

      sel = 1'b1;
      @(negedge clk);
      sweep(2'd0, 4, "settle3");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
